// File: rtl/sync_fifo_fwft_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft_prog
//
// Single-clock first-word-fall-through FIFO built from a synchronous-read RAM
// followed by a two-entry prefetch stage (head register + skid register).
// The head register drives RD_DATA directly, so the head word is visible
// without a read request. A read acknowledge (RD_EN) pops it.
//
// On top of the basic FIFO this block provides:
//   - an exact occupancy count (RAM + in-flight read + prefetch stage),
//   - almost-full / almost-empty flags against runtime thresholds,
//   - sticky overflow / underflow error flags with a clear input,
//   - a synchronous flush.
//
// Ports:
//   CLK           clock, all logic on the rising edge
//   RST           asynchronous active-high reset
//   FLUSH         synchronous flush, takes priority over WR_EN / RD_EN
//   WR_DATA       write data
//   WR_EN         write enable, ignored while WR_FULL is set
//   WR_FULL       registered full flag (DATA_COUNT == C_REAL_DEPTH)
//   RD_DATA       head-of-FIFO word, valid while RD_EMPTY is low
//   RD_EN         read acknowledge, pops RD_DATA
//   RD_EMPTY      registered empty flag for the output stage
//   AF_TH         almost-full threshold
//   AE_TH         almost-empty threshold
//   ALMOST_FULL   registered DATA_COUNT >= AF_TH
//   ALMOST_EMPTY  registered DATA_COUNT <= AE_TH
//   DATA_COUNT    number of entries held
//   WR_OVERFLOW   sticky: a write was attempted while full
//   RD_UNDERFLOW  sticky: a read was attempted while empty
//   CLR_ERR       clears both sticky flags
// ---------------------------------------------------------------------------
module sync_fifo_fwft_prog #(
  parameter int C_WIDTH      = 32,
  parameter int C_DEPTH      = 1024,
  parameter int C_REAL_DEPTH = 2 ** $clog2(C_DEPTH),
  parameter int C_DEPTH_BITS = $clog2(C_REAL_DEPTH),
  parameter int C_COUNT_BITS = $clog2(C_REAL_DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic [C_WIDTH-1:0]      WR_DATA,
  input  logic                    WR_EN,
  output logic                    WR_FULL,
  output logic [C_WIDTH-1:0]      RD_DATA,
  input  logic                    RD_EN,
  output logic                    RD_EMPTY,
  input  logic [C_COUNT_BITS-1:0] AF_TH,
  input  logic [C_COUNT_BITS-1:0] AE_TH,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic [C_COUNT_BITS-1:0] DATA_COUNT,
  output logic                    WR_OVERFLOW,
  output logic                    RD_UNDERFLOW,
  input  logic                    CLR_ERR
);

  logic [C_WIDTH-1:0]      mem [C_REAL_DEPTH];
  logic [C_WIDTH-1:0]      ram_q;

  logic [C_DEPTH_BITS-1:0] wr_ptr;
  logic [C_DEPTH_BITS-1:0] rd_ptr;
  logic [C_COUNT_BITS-1:0] count;
  logic [C_COUNT_BITS-1:0] count_next;
  logic [C_COUNT_BITS-1:0] ram_cnt;
  logic [C_COUNT_BITS-1:0] ram_cnt_next;
  logic                    rd_inflight;

  logic                    head_valid;
  logic [C_WIDTH-1:0]      head_data;
  logic                    skid_valid;
  logic [C_WIDTH-1:0]      skid_data;
  logic                    head_valid_next;
  logic [C_WIDTH-1:0]      head_data_next;
  logic                    skid_valid_next;
  logic [C_WIDTH-1:0]      skid_data_next;

  logic                    full_q;
  logic                    af_q;
  logic                    ae_q;
  logic                    ov_q;
  logic                    uf_q;

  logic                    wr_acc;
  logic                    pop;
  logic                    wr_err;
  logic                    rd_err;
  logic                    issue;
  logic [2:0]              stage_occ;

  // Accept / error decode. FLUSH masks everything so a flush cycle neither
  // moves data nor raises an error flag.
  always_comb begin
    wr_acc = WR_EN & ~full_q & ~FLUSH;
    pop    = RD_EN & head_valid & ~FLUSH;
    wr_err = WR_EN & full_q & ~FLUSH;
    rd_err = RD_EN & ~head_valid & ~FLUSH;
  end

  // RAM read issue. Words already in the prefetch stage plus the word still
  // in flight from the RAM, less the one being popped, must leave room for
  // the new word, so the two prefetch registers can never be overrun. With
  // one word in the head and one in flight a pop still issues, which keeps
  // back-to-back reads bubble free.
  always_comb begin
    stage_occ = 3'(head_valid) + 3'(skid_valid) + 3'(rd_inflight) - 3'(pop);
    issue     = (ram_cnt != '0) & (stage_occ < 3'd2) & ~FLUSH;
  end

  // Occupancy bookkeeping: the total count follows accepted writes/pops, the
  // RAM count follows accepted writes and RAM read issues.
  always_comb begin
    count_next   = count;
    ram_cnt_next = ram_cnt;
    if (FLUSH) begin
      count_next   = '0;
      ram_cnt_next = '0;
    end else begin
      if (wr_acc && !pop) begin
        count_next = count + C_COUNT_BITS'(1);
      end else if (!wr_acc && pop) begin
        count_next = count - C_COUNT_BITS'(1);
      end
      if (wr_acc && !issue) begin
        ram_cnt_next = ram_cnt + C_COUNT_BITS'(1);
      end else if (!wr_acc && issue) begin
        ram_cnt_next = ram_cnt - C_COUNT_BITS'(1);
      end
    end
  end

  // Prefetch stage update. A pop shifts the skid word into the head; when
  // nothing is behind the head its data is left alone so RD_DATA keeps its
  // last value. The word returning from the RAM then lands in the first
  // free slot, head first.
  always_comb begin
    head_valid_next = head_valid;
    head_data_next  = head_data;
    skid_valid_next = skid_valid;
    skid_data_next  = skid_data;
    if (pop) begin
      head_valid_next = skid_valid;
      if (skid_valid) begin
        head_data_next = skid_data;
      end
      skid_valid_next = 1'b0;
    end
    if (rd_inflight) begin
      if (!head_valid_next) begin
        head_valid_next = 1'b1;
        head_data_next  = ram_q;
      end else begin
        skid_valid_next = 1'b1;
        skid_data_next  = ram_q;
      end
    end
  end

  // Storage array and its registered read port; contents need no reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= WR_DATA;
    end
    if (issue) begin
      ram_q <= mem[rd_ptr];
    end
  end

  // Control state. Flags are derived from count_next so they line up with
  // DATA_COUNT in the same cycle; thresholds are sampled at the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      head_valid  <= 1'b0;
      head_data   <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      ov_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      count   <= count_next;
      ram_cnt <= ram_cnt_next;
      full_q  <= (count_next == C_COUNT_BITS'(C_REAL_DEPTH));
      af_q    <= (count_next >= AF_TH);
      ae_q    <= (count_next <= AE_TH);
      if (FLUSH) begin
        rd_ptr      <= wr_ptr;
        rd_inflight <= 1'b0;
        head_valid  <= 1'b0;
        skid_valid  <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + C_DEPTH_BITS'(1);
        end
        if (issue) begin
          rd_ptr <= rd_ptr + C_DEPTH_BITS'(1);
        end
        rd_inflight <= issue;
        head_valid  <= head_valid_next;
        head_data   <= head_data_next;
        skid_valid  <= skid_valid_next;
        skid_data   <= skid_data_next;
        // A fresh error event in the clearing cycle keeps its flag set.
        if (CLR_ERR) begin
          ov_q <= wr_err;
          uf_q <= rd_err;
        end else begin
          ov_q <= ov_q | wr_err;
          uf_q <= uf_q | rd_err;
        end
      end
    end
  end

  assign WR_FULL      = full_q;
  assign RD_DATA      = head_data;
  assign RD_EMPTY     = ~head_valid;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign DATA_COUNT   = count;
  assign WR_OVERFLOW  = ov_q;
  assign RD_UNDERFLOW = uf_q;

endmodule

// File: tb/tb_sync_fifo_fwft_prog.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft_prog
//
// Self-checking bench for sync_fifo_fwft_prog (C_WIDTH=8, C_DEPTH=16,
// AF_TH=14, AE_TH=2). Inputs change on the falling edge, outputs are sampled
// on the falling edge. Written words are pushed into a scoreboard queue and
// popped when the bench acknowledges a read of the head word.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft_prog;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CB = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          FLUSH = 1'b0;
  logic [W-1:0]  WR_DATA = '0;
  logic          WR_EN = 1'b0;
  logic          WR_FULL;
  logic [W-1:0]  RD_DATA;
  logic          RD_EN = 1'b0;
  logic          RD_EMPTY;
  logic [CB-1:0] AF_TH = 5'd14;
  logic [CB-1:0] AE_TH = 5'd2;
  logic          ALMOST_FULL;
  logic          ALMOST_EMPTY;
  logic [CB-1:0] DATA_COUNT;
  logic          WR_OVERFLOW;
  logic          RD_UNDERFLOW;
  logic          CLR_ERR = 1'b0;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  sb[$];
  int            mcount = 0;

  sync_fifo_fwft_prog #(
    .C_WIDTH(W),
    .C_DEPTH(D)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .FLUSH(FLUSH),
    .WR_DATA(WR_DATA),
    .WR_EN(WR_EN),
    .WR_FULL(WR_FULL),
    .RD_DATA(RD_DATA),
    .RD_EN(RD_EN),
    .RD_EMPTY(RD_EMPTY),
    .AF_TH(AF_TH),
    .AE_TH(AE_TH),
    .ALMOST_FULL(ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY),
    .DATA_COUNT(DATA_COUNT),
    .WR_OVERFLOW(WR_OVERFLOW),
    .RD_UNDERFLOW(RD_UNDERFLOW),
    .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  // Drives one clock cycle from a falling edge to the next falling edge and
  // updates the reference model: a write is accepted when the model holds
  // fewer than D words, a read when the head word is presented. Returns the
  // word seen at RD_DATA and the scoreboard word it should equal.
  task automatic apply_stimulus(input logic wr, input logic [W-1:0] d, input logic rd,
                                input logic fl, input logic clr,
                                output logic popped, output logic [W-1:0] got,
                                output logic [W-1:0] exp);
    logic wacc;
    WR_EN   = wr;
    WR_DATA = d;
    RD_EN   = rd;
    FLUSH   = fl;
    CLR_ERR = clr;
    got     = RD_DATA;
    exp     = 'x;
    popped  = 1'b0;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      wacc   = wr && (mcount < D);
      popped = rd && !RD_EMPTY;
      if (popped && sb.size() > 0) begin
        exp = sb.pop_front();
        mcount--;
      end
      if (wacc) begin
        sb.push_back(d);
        mcount++;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    WR_EN   = 1'b0;
    RD_EN   = 1'b0;
    FLUSH   = 1'b0;
    CLR_ERR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2;
    checks++;
    if ({DATA_COUNT, WR_FULL, RD_EMPTY, RD_DATA, ALMOST_EMPTY, ALMOST_FULL, WR_OVERFLOW, RD_UNDERFLOW}
        !== {5'd0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got cnt=%0d full=%b empty=%b data=%h ae=%b af=%b ov=%b uf=%b expected 0 0 1 00 1 0 0 0",
               DATA_COUNT, WR_FULL, RD_EMPTY, RD_DATA, ALMOST_EMPTY, ALMOST_FULL, WR_OVERFLOW, RD_UNDERFLOW);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    mcount = 0;
  endtask

  task automatic test_fill();
    logic p;
    logic [W-1:0] g, e;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, p, g, e);
      checks++;
      if (DATA_COUNT !== 5'(i + 1)) begin
        errors++;
        $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, DATA_COUNT, i + 1);
      end
      checks++;
      if (ALMOST_FULL !== (i + 1 >= 14)) begin
        errors++;
        $display("[TB] FAIL fill_almost_full[%0d]: got %b expected %b", i, ALMOST_FULL, (i + 1 >= 14));
      end
      checks++;
      if (WR_FULL !== (i + 1 == 16)) begin
        errors++;
        $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, WR_FULL, (i + 1 == 16));
      end
      checks++;
      if (ALMOST_EMPTY !== (i + 1 <= 2)) begin
        errors++;
        $display("[TB] FAIL fill_almost_empty[%0d]: got %b expected %b", i, ALMOST_EMPTY, (i + 1 <= 2));
      end
      checks++;
      if (RD_EMPTY !== (i < 2)) begin
        errors++;
        $display("[TB] FAIL fill_latency[%0d]: got empty=%b expected %b", i, RD_EMPTY, (i < 2));
      end
      if (i == 2) begin
        checks++;
        if (RD_DATA !== 8'h00) begin
          errors++;
          $display("[TB] FAIL fill_first_word: got %h expected 00", RD_DATA);
        end
      end
    end
  endtask

  task automatic test_drain();
    logic p;
    logic [W-1:0] g, e;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
      checks++;
      if (!p || g !== e) begin
        errors++;
        $display("[TB] FAIL drain_data[%0d]: got popped=%b data=%h expected popped=1 data=%h", i, p, g, e);
      end
      checks++;
      if (DATA_COUNT !== 5'(15 - i) || ALMOST_EMPTY !== (15 - i <= 2)) begin
        errors++;
        $display("[TB] FAIL drain_count[%0d]: got cnt=%0d ae=%b expected cnt=%0d ae=%b",
                 i, DATA_COUNT, ALMOST_EMPTY, 15 - i, (15 - i <= 2));
      end
    end
    checks++;
    if (RD_EMPTY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_empty: got %b expected 1", RD_EMPTY);
    end
  endtask

  task automatic test_simultaneous();
    logic p;
    logic [W-1:0] g, e;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, p, g, e);
    repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b0 || DATA_COUNT !== 5'd8) begin
      errors++;
      $display("[TB] FAIL sim_setup: got empty=%b cnt=%0d expected 0 8", RD_EMPTY, DATA_COUNT);
    end
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, 8'(8'h28 + i), 1'b1, 1'b0, 1'b0, p, g, e);
      checks++;
      if (!p || g !== e) begin
        errors++;
        $display("[TB] FAIL sim_data[%0d]: got popped=%b data=%h expected popped=1 data=%h", i, p, g, e);
      end
      checks++;
      if (DATA_COUNT !== 5'd8) begin
        errors++;
        $display("[TB] FAIL sim_count[%0d]: got %0d expected 8", i, DATA_COUNT);
      end
    end
    for (int n = 0; n < 40 && mcount > 0; n++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
      if (p) begin
        checks++;
        if (g !== e) begin
          errors++;
          $display("[TB] FAIL sim_tail: got %h expected %h", g, e);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || RD_EMPTY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sim_drain_done: got left=%0d empty=%b expected 0 1", sb.size(), RD_EMPTY);
    end
  endtask

  task automatic test_errors();
    logic p;
    logic [W-1:0] g, e;
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, p, g, e);
    repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, p, g, e);
    apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (WR_OVERFLOW !== 1'b1 || DATA_COUNT !== 5'd16 || RD_UNDERFLOW !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_set: got ov=%b cnt=%0d uf=%b expected 1 16 0", WR_OVERFLOW, DATA_COUNT, RD_UNDERFLOW);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, p, g, e);
    checks++;
    if ({WR_OVERFLOW, RD_UNDERFLOW} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL clear_overflow: got ov=%b uf=%b expected 0 0", WR_OVERFLOW, RD_UNDERFLOW);
    end
    apply_stimulus(1'b1, 8'hAB, 1'b0, 1'b0, 1'b1, p, g, e);
    checks++;
    if (WR_OVERFLOW !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_vs_overflow: got %b expected 1", WR_OVERFLOW);
    end
    apply_stimulus(1'b1, 8'hAC, 1'b1, 1'b0, 1'b0, p, g, e);
    checks++;
    if (!p || g !== e || DATA_COUNT !== 5'd15) begin
      errors++;
      $display("[TB] FAIL full_write_with_read: got popped=%b data=%h cnt=%0d expected 1 %h 15", p, g, DATA_COUNT, e);
    end
    for (int n = 0; n < 40 && mcount > 0; n++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
      if (p) begin
        checks++;
        if (g !== e) begin
          errors++;
          $display("[TB] FAIL err_drain: got %h expected %h", g, e);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || RD_EMPTY !== 1'b1 || DATA_COUNT !== 5'd0) begin
      errors++;
      $display("[TB] FAIL err_drain_done: got left=%0d empty=%b cnt=%0d expected 0 1 0", sb.size(), RD_EMPTY, DATA_COUNT);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_UNDERFLOW !== 1'b1 || DATA_COUNT !== 5'd0) begin
      errors++;
      $display("[TB] FAIL underflow_set: got uf=%b cnt=%0d expected 1 0", RD_UNDERFLOW, DATA_COUNT);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, p, g, e);
    checks++;
    if ({WR_OVERFLOW, RD_UNDERFLOW} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL clear_both: got ov=%b uf=%b expected 0 0", WR_OVERFLOW, RD_UNDERFLOW);
    end
    apply_stimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_UNDERFLOW !== 1'b1 || DATA_COUNT !== 5'd1) begin
      errors++;
      $display("[TB] FAIL underflow_with_write: got uf=%b cnt=%0d expected 1 1", RD_UNDERFLOW, DATA_COUNT);
    end
    repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, p, g, e);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, p, g, e);
    checks++;
    if (!p || g !== e) begin
      errors++;
      $display("[TB] FAIL underflow_write_kept: got popped=%b data=%h expected 1 %h", p, g, e);
    end
  endtask

  task automatic test_flush();
    logic p;
    logic [W-1:0] g, e;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, p, g, e);
    repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b0 || DATA_COUNT !== 5'd5) begin
      errors++;
      $display("[TB] FAIL flush_setup: got empty=%b cnt=%0d expected 0 5", RD_EMPTY, DATA_COUNT);
    end
    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, p, g, e);
    checks++;
    if (DATA_COUNT !== 5'd0 || RD_EMPTY !== 1'b1 || WR_FULL !== 1'b0 || RD_DATA !== 8'h60) begin
      errors++;
      $display("[TB] FAIL flush_state: got cnt=%0d empty=%b full=%b data=%h expected 0 1 0 60",
               DATA_COUNT, RD_EMPTY, WR_FULL, RD_DATA);
    end
    apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b1 || DATA_COUNT !== 5'd1) begin
      errors++;
      $display("[TB] FAIL flush_rewrite_k: got empty=%b cnt=%0d expected 1 1", RD_EMPTY, DATA_COUNT);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_rewrite_k1: got empty=%b expected 1", RD_EMPTY);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b0 || RD_DATA !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL flush_rewrite_k2: got empty=%b data=%h expected 0 5a", RD_EMPTY, RD_DATA);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
    checks++;
    if (!p || g !== e || RD_EMPTY !== 1'b1 || DATA_COUNT !== 5'd0) begin
      errors++;
      $display("[TB] FAIL flush_pop: got popped=%b data=%h empty=%b cnt=%0d expected 1 %h 1 0",
               p, g, RD_EMPTY, DATA_COUNT, e);
    end
  endtask

  task automatic test_async_reset();
    logic p;
    logic [W-1:0] g, e;
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, p, g, e);
    repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (DATA_COUNT !== 5'd10 || RD_EMPTY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_setup: got cnt=%0d empty=%b expected 10 0", DATA_COUNT, RD_EMPTY);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({DATA_COUNT, WR_FULL, RD_EMPTY, RD_DATA, ALMOST_EMPTY, ALMOST_FULL, WR_OVERFLOW, RD_UNDERFLOW}
        !== {5'd0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL areset_values: got cnt=%0d full=%b empty=%b data=%h ae=%b af=%b ov=%b uf=%b expected 0 0 1 00 1 0 0 0",
               DATA_COUNT, WR_FULL, RD_EMPTY, RD_DATA, ALMOST_EMPTY, ALMOST_FULL, WR_OVERFLOW, RD_UNDERFLOW);
    end
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    mcount = 0;
    apply_stimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b1 || DATA_COUNT !== 5'd1) begin
      errors++;
      $display("[TB] FAIL areset_first_k: got empty=%b cnt=%0d expected 1 1", RD_EMPTY, DATA_COUNT);
    end
    apply_stimulus(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_first_k1: got empty=%b expected 1", RD_EMPTY);
    end
    apply_stimulus(1'b1, 8'hC5, 1'b0, 1'b0, 1'b0, p, g, e);
    checks++;
    if (RD_EMPTY !== 1'b0 || RD_DATA !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL areset_first_k2: got empty=%b data=%h expected 0 c3", RD_EMPTY, RD_DATA);
    end
    for (int n = 0; n < 20 && mcount > 0; n++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, p, g, e);
      if (p) begin
        checks++;
        if (g !== e) begin
          errors++;
          $display("[TB] FAIL areset_drain: got %h expected %h", g, e);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || RD_EMPTY !== 1'b1 || DATA_COUNT !== 5'd0) begin
      errors++;
      $display("[TB] FAIL areset_drain_done: got left=%0d empty=%b cnt=%0d expected 0 1 0", sb.size(), RD_EMPTY, DATA_COUNT);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_errors();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sync_fifo_fwft_prog.md
Name: sync_fifo_fwft_prog

Overview:
- Single-clock first-word-fall-through FIFO with an internal RAM and a prefetch output stage.
- Adds to our FWFT FIFO family: exact occupancy count, runtime-programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Used as the intra-domain buffer in TSN datapaths where frame schedulers need fill-level back-pressure.

Parameters:
- C_WIDTH, 32, data bus width in bits.
- C_DEPTH, 1024, requested depth; rounded up to C_REAL_DEPTH.
- C_REAL_DEPTH, 2**clog2(C_DEPTH), total entry capacity, prefetch stage included.
- C_DEPTH_BITS, clog2(C_REAL_DEPTH), RAM address width.
- C_COUNT_BITS, clog2(C_REAL_DEPTH+1), width of count and threshold ports.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset.
- FLUSH  input  1  synchronous flush, high active.
- WR_DATA  input  C_WIDTH  write data.
- WR_EN  input  1  write enable, high active.
- WR_FULL  output  1  full; count == C_REAL_DEPTH.
- RD_DATA  output  C_WIDTH  head-of-FIFO data; valid while RD_EMPTY=0.
- RD_EN  input  1  read acknowledge; pops the current RD_DATA.
- RD_EMPTY  output  1  no valid data at RD_DATA.
- AF_TH  input  C_COUNT_BITS  almost-full threshold.
- AE_TH  input  C_COUNT_BITS  almost-empty threshold.
- ALMOST_FULL  output  1  count >= AF_TH.
- ALMOST_EMPTY  output  1  count <= AE_TH.
- DATA_COUNT  output  C_COUNT_BITS  entries held, RAM plus prefetch.
- WR_OVERFLOW  output  1  sticky flag: a write was attempted while full.
- RD_UNDERFLOW  output  1  sticky flag: a read was attempted while empty.
- CLR_ERR  input  1  clears both sticky flags.

Behaviour:
- Reset: asynchronous, active-high.
  - While RST=1: DATA_COUNT=0, WR_FULL=0, RD_EMPTY=1, RD_DATA=0, ALMOST_EMPTY=1, ALMOST_FULL=0, WR_OVERFLOW=0, RD_UNDERFLOW=0.
  - Pointers and prefetch valids clear.
  - RAM contents are don't-care.
- Accepted write: WR_EN=1 && WR_FULL=0 at a clock edge. Accepted read: RD_EN=1 && RD_EMPTY=0 at a clock edge. WR_FULL and RD_EMPTY are the registered values.
- DATA_COUNT is registered and updates on the edge of the accept: +1 for write only, -1 for read only, unchanged for both.
- WR_FULL, ALMOST_FULL and ALMOST_EMPTY are registered and consistent with DATA_COUNT in the same cycle. Threshold changes take effect on the next edge.
- FWFT latency:
  - A write accepted at edge k into an empty FIFO drives RD_EMPTY=0 and RD_DATA=that word after edge k+2.
  - While entries are back-to-back, an accepted read at edge k presents the next word after edge k; no bubble is allowed.
  - The prefetch stage must hold up to 2 words so that synchronous RAM read latency never starves the output.
- RD_DATA is stable while RD_EMPTY=0 and RD_EN=0.
- Ordering is strict FIFO. The pointer wraps modulo C_REAL_DEPTH.
- Write while full: ignored, count and data unchanged, WR_OVERFLOW=1 from the next edge. This holds even when RD_EN is accepted in the same cycle; the read proceeds.
- Read while empty: ignored, RD_UNDERFLOW=1 from the next edge. A simultaneous write is still accepted.
- CLR_ERR=1 clears both sticky flags on the next edge. A new error event in the same cycle wins; the flag stays 1.
- FLUSH=1 has priority over WR_EN and RD_EN. On the next edge:
  - count=0, RD_EMPTY=1, WR_FULL=0, prefetch invalidated, pointers equal.
  - Sticky flags are unchanged.
  - RD_DATA holds its last value.
- RST asserted mid-operation aborts all in-flight prefetch. The first write after release observes the empty-FIFO latency above.

Test Plan (C_WIDTH=8, C_DEPTH=16, AF_TH=14, AE_TH=2):
- Fill: write 0x00..0x0F back-to-back from empty.
  - -> RD_EMPTY falls 2 edges after the first write, with RD_DATA=0x00.
  - -> WR_FULL=1 when DATA_COUNT=16.
  - -> ALMOST_FULL=1 from DATA_COUNT=14.
- Drain: hold RD_EN=1 on the full FIFO.
  - -> RD_DATA sequence 0x00..0x0F with no gaps.
  - -> RD_EMPTY=1 after the 16th pop, DATA_COUNT=0, ALMOST_EMPTY=1 from count 2.
- Simultaneous: at count 8, assert WR_EN and RD_EN for 40 cycles with an incrementing pattern.
  - -> DATA_COUNT stays 8.
  - -> Output order matches; pointers wrap twice with no corruption.
- Errors:
  - Write 0xAA while full -> WR_OVERFLOW=1, 0xAA never read out.
  - Read while empty -> RD_UNDERFLOW=1.
  - CLR_ERR pulse -> both flags 0.
  - CLR_ERR coincident with a new overflow -> WR_OVERFLOW stays 1.
- Flush: at count 5 with RD_EMPTY=0, pulse FLUSH alongside WR_EN=1.
  - -> Next cycle DATA_COUNT=0, RD_EMPTY=1, the write is dropped.
  - -> A subsequent write of 0x5A appears 2 edges later.
- Async reset: assert RST between clock edges at count 10.
  - -> Outputs reach their reset values before the next edge.
  - -> After release, FIFO operation is normal.
